// File: rtl/cosmem_ctrl.sv
`timescale 1ns/1ps
// COSMAC 1802 memory/bus controller: XCLK, /CLEAR, /WAIT sequencing,
// MA demux, window decode and 1802-to-block-RAM read/write bridge.
//
// Ports:
//   clk, reset              system clock, async active-high reset
//   xclk, clr, nwait        1802 clock and mode pins
//   pause_req               host request for PAUSE mode
//   nmwr, nmrd, tpa, tpb    CPU strobes (asynchronous to clk)
//   ma                      multiplexed address from CPU
//   db_in/db_out/db_oe      data bus pad interface
//   ce                      current access hits the RAM window
//   mem_*                   synchronous RAM port (1-clk read latency)
//   wp_violation            blocked write into the ROM region
//   probe                   LED: high in clear, toggles per access
module cosmem_ctrl #(
  parameter int MEM_WORDS  = 8192,
  parameter int XCLK_DIV   = 8,
  parameter int CLR_CYCLES = 16,
  parameter int ROM_WORDS  = 0,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          xclk,
  output logic          nwait,
  output logic          clr,
  input  logic          pause_req,
  input  logic          nmwr,
  input  logic          nmrd,
  input  logic          tpa,
  input  logic          tpb,
  input  logic [7:0]    ma,
  input  logic [7:0]    db_in,
  output logic [7:0]    db_out,
  output logic          db_oe,
  output logic          ce,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  input  logic [7:0]    mem_rdata,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  output logic          wp_violation,
  output logic          probe
);

  localparam int DW = $clog2(XCLK_DIV);
  localparam int CW = $clog2(CLR_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_DRIVE,
    S_WR_ARM,
    S_WR_DONE
  } state_t;

  // clock divider and mode pins
  logic [DW-1:0] r_div;
  logic [CW-1:0] r_ccnt;
  logic          r_xclk;
  logic          r_clr;
  logic          r_nwait;
  logic          w_xrise;
  logic          w_xfall;

  assign w_xrise = (r_div == DW'(XCLK_DIV / 2 - 1));
  assign w_xfall = (r_div == DW'(XCLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div   <= '0;
      r_xclk  <= 1'b0;
      r_ccnt  <= '0;
      r_clr   <= 1'b0;
      r_nwait <= 1'b1;
    end else begin
      r_div <= w_xfall ? '0 : r_div + DW'(1);
      if (w_xrise || w_xfall)
        r_xclk <= ~r_xclk;
      // clr releases on the CLR_CYCLES-th rising edge of xclk
      if (w_xrise && !r_clr) begin
        if (r_ccnt == CW'(CLR_CYCLES - 1))
          r_clr <= 1'b1;
        else
          r_ccnt <= r_ccnt + CW'(1);
      end
      if (w_xfall)
        r_nwait <= !(pause_req && r_clr);
    end
  end

  // 2-FF synchronisers plus one delay stage for edge detection
  logic [1:0] r_mwr_s, r_mrd_s, r_tpa_s, r_tpb_s;
  logic [7:0] r_ma_s1, r_ma_s2;
  logic       r_mwr_d, r_tpa_d, r_tpb_d, r_mrd_d;
  logic       w_mwr, w_mrd, w_tpa, w_tpb;
  logic [7:0] w_ma;

  assign w_mwr = r_mwr_s[1];
  assign w_mrd = r_mrd_s[1];
  assign w_tpa = r_tpa_s[1];
  assign w_tpb = r_tpb_s[1];
  assign w_ma  = r_ma_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mwr_s <= 2'b11;
      r_mrd_s <= 2'b11;
      r_tpa_s <= 2'b00;
      r_tpb_s <= 2'b00;
      r_ma_s1 <= '0;
      r_ma_s2 <= '0;
      r_mwr_d <= 1'b1;
      r_mrd_d <= 1'b1;
      r_tpa_d <= 1'b0;
      r_tpb_d <= 1'b0;
    end else begin
      r_mwr_s <= {r_mwr_s[0], nmwr};
      r_mrd_s <= {r_mrd_s[0], nmrd};
      r_tpa_s <= {r_tpa_s[0], tpa};
      r_tpb_s <= {r_tpb_s[0], tpb};
      r_ma_s1 <= ma;
      r_ma_s2 <= r_ma_s1;
      r_mwr_d <= w_mwr;
      r_mrd_d <= w_mrd;
      r_tpa_d <= w_tpa;
      r_tpb_d <= w_tpb;
    end
  end

  logic w_mwr_fall, w_mwr_rise, w_mrd_fall;
  logic w_tpa_fall, w_tpb_rise;

  assign w_mwr_fall = r_mwr_d & ~w_mwr;
  assign w_mwr_rise = ~r_mwr_d & w_mwr;
  assign w_mrd_fall = r_mrd_d & ~w_mrd;
  assign w_tpa_fall = r_tpa_d & ~w_tpa;
  assign w_tpb_rise = ~r_tpb_d & w_tpb;

  // address demux and decode
  logic [7:0]  r_hi;
  logic [15:0] r_addr;
  logic [15:0] w_addr;
  logic        w_in_win;
  logic        w_rom;

  assign w_addr   = {r_hi, w_ma};
  // only the bits above AW matter; shift keeps AW=16 legal
  assign w_in_win = (({1'b0, w_addr} >> AW) == 17'd0);
  assign w_rom    = ({1'b0, r_addr} < 17'(ROM_WORDS));

  // access FSM
  state_t r_state, w_next;
  logic   w_start, w_fire, w_done;

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_fire  = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // both strobes low counts as a write
        if (w_mwr_fall && w_in_win) begin
          w_next  = S_WR_ARM;
          w_start = 1'b1;
        end else if (w_mrd_fall && w_mwr && w_in_win) begin
          w_next  = S_RD_REQ;
          w_start = 1'b1;
        end
      end
      S_RD_REQ:
        w_next = w_mwr ? S_RD_DRIVE : S_WR_ARM;
      S_RD_DRIVE: begin
        if (!w_mwr) begin
          w_next = S_WR_ARM;
        end else if (w_mrd) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end
      end
      S_WR_ARM: begin
        if (w_tpb_rise || w_mwr_rise) begin
          w_next = S_WR_DONE;
          w_fire = 1'b1;
        end
      end
      S_WR_DONE: begin
        if (w_mwr) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  logic       r_ce;
  logic       r_we;
  logic       r_wp;
  logic [7:0] r_wdata;
  logic       r_rd_first;
  logic [7:0] r_db;
  logic       r_probe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_hi       <= '0;
      r_addr     <= '0;
      r_ce       <= 1'b0;
      r_we       <= 1'b0;
      r_wp       <= 1'b0;
      r_wdata    <= '0;
      r_rd_first <= 1'b0;
      r_db       <= '0;
      r_probe    <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_tpa_fall)
        r_hi <= w_ma;
      if (w_start) begin
        r_addr <= w_addr;
        r_ce   <= 1'b1;
      end else if (w_done) begin
        r_ce <= 1'b0;
      end
      r_we <= w_fire && !w_rom;
      r_wp <= w_fire && w_rom;
      if (w_fire)
        r_wdata <= db_in;
      r_rd_first <= (r_state == S_RD_REQ) && (w_next == S_RD_DRIVE);
      if (r_rd_first)
        r_db <= mem_rdata;
      if (w_done)
        r_probe <= ~r_probe;
    end
  end

  assign xclk         = r_xclk;
  assign clr          = r_clr;
  assign nwait        = r_nwait;
  assign ce           = r_ce;
  assign mem_addr     = r_addr[AW-1:0];
  assign mem_re       = (r_state == S_RD_REQ);
  assign mem_we       = r_we;
  assign mem_wdata    = r_wdata;
  assign wp_violation = r_wp;
  // RAM data arrives in the first drive cycle; pass it straight through
  assign db_out       = r_rd_first ? mem_rdata : r_db;
  assign db_oe        = (r_state == S_RD_DRIVE) && !w_mrd
                        && w_mwr && r_clr;
  assign probe        = r_clr ? r_probe : 1'b1;

endmodule
